// File: rtl/i2s_rx_ctrl.sv
// I2S receive-side master controller: generates bck/lrck from clk with a
// programmable half-period divider, sequences start/stop on frame boundaries,
// and captures one stereo sample per frame into a valid/ready holding register.
module i2s_rx_ctrl #(
    parameter int unsigned WORD_SIZE = 24,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned CAP_BIT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 bck,
    output logic                 lrck,
    output logic                 running,
    output logic                 frame_start,
    input  logic [WORD_SIZE-1:0] l_in,
    input  logic [WORD_SIZE-1:0] r_in,
    output logic [WORD_SIZE-1:0] sample_l,
    output logic [WORD_SIZE-1:0] sample_r,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] div_lat;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [BIT_W-1:0]     bit_cnt;

    logic                 div_hit;
    logic                 fall;
    logic                 wrap;
    logic                 cap;
    logic                 accept;
    logic                 load;
    logic [BIT_W-1:0]     bit_nxt;

    // Divider terminal count, falling-edge events, capture and handshake decode
    always_comb begin
        div_hit = (state != IDLE) && (div_cnt == div_lat);
        fall    = div_hit && bck;
        bit_nxt = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
        wrap    = fall && (bit_nxt == '0);
        cap     = fall && (bit_nxt == BIT_W'(CAP_BIT));
        accept  = sample_valid && sample_ready;
        // an accept in the capture clk frees the register for the new word
        load    = cap && (!sample_valid || accept);
    end

    // Sequencer, clock generation, capture register and overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_lat      <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            bck          <= 1'b0;
            lrck         <= 1'b0;
            running      <= 1'b0;
            frame_start  <= 1'b0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (en) begin
                        state       <= RUN;
                        running     <= 1'b1;
                        div_lat     <= div;
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        bck         <= 1'b0;
                        lrck        <= 1'b0;
                        frame_start <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (div_hit) begin
                        div_cnt <= '0;
                        bck     <= ~bck;
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end

                    if (fall) begin
                        bit_cnt <= bit_nxt;
                        lrck    <= (bit_nxt >= BIT_W'(SLOT_BITS));
                    end

                    // a stop request completes only at the frame wrap
                    if (wrap && (state == DRAIN) && !en) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        bck     <= 1'b0;
                        lrck    <= 1'b0;
                        div_cnt <= '0;
                    end else begin
                        if (wrap) begin
                            frame_start <= 1'b1;
                        end
                        state <= en ? RUN : DRAIN;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    bck     <= 1'b0;
                    lrck    <= 1'b0;
                end
            endcase

            if (load) begin
                sample_l     <= l_in;
                sample_r     <= r_in;
                sample_valid <= 1'b1;
            end else if (accept) begin
                sample_valid <= 1'b0;
            end

            // a dropped capture outranks a simultaneous clear
            if (cap && !load) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Self-checking bench for i2s_rx_ctrl: a time-based reference model predicts
// bck/lrck/frame_start/running from elapsed clocks, and a scoreboard queue
// holds the stereo words expected at each downstream handshake.
module tb_i2s_rx_ctrl;

    localparam int WS    = 24;
    localparam int SLOT  = 32;
    localparam int DW    = 8;
    localparam int CAP   = 4;
    localparam int FRAME = 2 * SLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] div;
    logic          bck;
    logic          lrck;
    logic          running;
    logic          frame_start;
    logic [WS-1:0] l_in;
    logic [WS-1:0] r_in;
    logic [WS-1:0] sample_l;
    logic [WS-1:0] sample_r;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;
    logic          overrun_clr;

    i2s_rx_ctrl #(
        .WORD_SIZE(WS),
        .SLOT_BITS(SLOT),
        .DIV_WIDTH(DW),
        .CAP_BIT  (CAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .div         (div),
        .bck         (bck),
        .lrck        (lrck),
        .running     (running),
        .frame_start (frame_start),
        .l_in        (l_in),
        .r_in        (r_in),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state: elapsed clocks since start, bck period in clocks
    int   m_active = 0;
    int   m_drain  = 0;
    int   m_t      = 0;
    int   m_P      = 2;
    bit   m_valid  = 1'b0;
    bit   m_ovr    = 1'b0;
    bit   mon_on   = 1'b0;
    logic [5:0]      e_ctl = '0;
    logic [2*WS-1:0] sb[$];

    // behavioural model: bck phase, bit index and frame position follow from m_t
    always @(posedge clk) begin
        bit cap;
        bit acc;
        bit set_ovr;
        int bitc;
        bit e_bck;
        bit e_lrck;
        bit e_fs;
        cap     = 1'b0;
        set_ovr = 1'b0;
        if (rst) begin
            m_active = 0;
            m_drain  = 0;
            m_t      = 0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            sb.delete();
            e_ctl    = '0;
            mon_on   = 1'b1;
        end else begin
            if (m_active == 0) begin
                if (en) begin
                    m_active = 1;
                    m_drain  = 0;
                    m_P      = 2 * (int'(div) + 1);
                    m_t      = 0;
                end
            end else begin
                m_t = m_t + 1;
                if (m_drain != 0 && !en && (m_t % (FRAME * m_P)) == 0) begin
                    m_active = 0;
                end else begin
                    m_drain = en ? 0 : 1;
                end
                if (m_active != 0 && (m_t % m_P) == 0 && ((m_t / m_P) % FRAME) == CAP)
                    cap = 1'b1;
            end

            acc = m_valid && sample_ready;
            if (cap && (!m_valid || acc)) begin
                sb.push_back({l_in, r_in});
                m_valid = 1'b1;
            end else if (cap) begin
                set_ovr = 1'b1;
            end else if (acc) begin
                m_valid = 1'b0;
            end
            if (overrun_clr) m_ovr = 1'b0;
            if (set_ovr)     m_ovr = 1'b1;

            if (m_active != 0) begin
                bitc   = (m_t / m_P) % FRAME;
                e_bck  = ((m_t / (m_P / 2)) % 2) == 1;
                e_lrck = bitc >= SLOT;
                e_fs   = (m_t % (FRAME * m_P)) == 0;
                e_ctl  = {1'b1, e_bck, e_lrck, e_fs, m_valid, m_ovr};
            end else begin
                e_ctl  = {4'b0000, m_valid, m_ovr};
            end
        end
    end

    // monitor: control outputs every clk, sample words on every presented output
    always @(negedge clk) begin
        if (mon_on) begin
            total++;
            if ({running, bck, lrck, frame_start, sample_valid, overrun} !== e_ctl) begin
                bad++;
                $display("FAIL ctl t=%0t: got run/bck/lrck/fs/vld/ovr=%b expected %b",
                         $time, {running, bck, lrck, frame_start, sample_valid, overrun}, e_ctl);
            end
            if (sample_valid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty t=%0t: got valid data %h expected no sample",
                             $time, {sample_l, sample_r});
                end else begin
                    if ({sample_l, sample_r} !== sb[0]) begin
                        bad++;
                        $display("FAIL sample t=%0t: got %h expected %h",
                                 $time, {sample_l, sample_r}, sb[0]);
                    end
                    if (sample_ready === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // wait until the model reaches a given clock offset within the frame
    task automatic wait_phase(input int ph, input int budget, input string name);
        int n;
        n = 0;
        while (!(m_active != 0 && (m_t % (FRAME * m_P)) == ph) && n < budget) begin
            step(1);
            n++;
        end
        total++;
        if (!(m_active != 0 && (m_t % (FRAME * m_P)) == ph)) begin
            bad++;
            $display("FAIL %s: timeout after %0d clk, got phase %0d expected %0d",
                     name, n, m_t, ph);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        en           = 1'b0;
        div          = '0;
        l_in         = '0;
        r_in         = '0;
        sample_ready = 1'b0;
        overrun_clr  = 1'b0;
        step(3);
        chk("reset_state", 64'({bck, lrck, running, frame_start, sample_valid, overrun,
                                sample_l, sample_r}), 64'd0);
        rst = 1'b0;

        // div=1: bck period 4, frame 256 clk, fixed data, always ready
        div          = 8'd1;
        en           = 1'b1;
        sample_ready = 1'b1;
        l_in         = 24'hA5A5A5;
        r_in         = 24'h5A5A5A;
        step(3 * 256 + 10);

        // div=0, then a div change mid-run must not alter the period
        pulse_rst();
        div = 8'd0;
        en  = 1'b1;
        step(20);
        div = 8'd5;
        step(400);

        // stop at bit 10, drain to the frame wrap, restart with a new div
        pulse_rst();
        div = 8'd1;
        en  = 1'b1;
        wait_phase(10 * 4, 300, "reach_bit10");
        en  = 1'b0;
        div = 8'd2;
        chk("drain_running", 64'(running), 64'd1);
        n = 0;
        while (m_active != 0 && n < 400) begin
            step(1);
            n++;
        end
        chk("drain_idle_outputs", 64'({running, bck, lrck}), 64'd0);
        step(50);
        en = 1'b1;
        step(2 * FRAME * 6 + 10);

        // overrun: no ready across two further captures, then clear and reload
        pulse_rst();
        div          = 8'd0;
        sample_ready = 1'b0;
        l_in         = 24'h000001;
        r_in         = 24'h000007;
        en           = 1'b1;
        wait_phase(CAP * 2, 300, "first_capture");
        l_in = 24'h000002;
        step(2 * FRAME * 2);
        chk("hold_old_word", 64'(sample_l), 64'h000001);
        chk("overrun_set", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("overrun_clr", 64'(overrun), 64'd0);
        wait_phase(CAP * 2 - 1, 300, "pre_capture");
        sample_ready = 1'b1;
        step(1);
        sample_ready = 1'b0;
        chk("reload_valid", 64'(sample_valid), 64'd1);
        chk("reload_word", 64'(sample_l), 64'h000002);
        chk("reload_no_ovr", 64'(overrun), 64'd0);

        // randomized traffic: data, ready, clears, occasional start/stop and div
        pulse_rst();
        en = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            sample_ready = 1'($urandom_range(0, 1));
            l_in         = WS'($urandom);
            r_in         = WS'($urandom);
            overrun_clr  = ($urandom_range(0, 39) == 0);
            div          = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) en = ~en;
            step(1);
        end
        overrun_clr = 1'b0;

        // reset while running mid-frame
        en = 1'b1;
        step(200);
        chk("pre_reset_running", 64'(running), 64'd1);
        rst = 1'b1;
        step(1);
        chk("midframe_reset", 64'({bck, lrck, running, frame_start, sample_valid, overrun,
                                   sample_l, sample_r}), 64'd0);
        rst = 1'b0;
        en  = 1'b0;
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
